// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: register selects, hazard cause encoding and the
// perf-counter width used by the hazard controller.
package cpu_types_pkg;

  localparam int HZ_PERF_W = 32;

  typedef logic [4:0] regbits_t;

  typedef enum logic [2:0] {
    HZ_NONE     = 3'd0,
    HZ_DMEM     = 3'd1,
    HZ_REDIRECT = 3'd2,
    HZ_LOADUSE  = 3'd3,
    HZ_IMISS    = 3'd4
  } hazard_cause_t;

endpackage

// File: rtl/load_scoreboard.sv
// Per-register countdown of loads still in flight after EX; hit flags an ID
// source that names a register whose load data is not yet forwardable.
module load_scoreboard #(
  parameter int NREGS    = 32,
  parameter int RW       = 5,
  parameter int LOAD_LAT = 0
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          set,
  input  logic [RW-1:0] set_sel,
  input  logic          adv,
  input  logic [RW-1:0] rsel1,
  input  logic [RW-1:0] rsel2,
  input  logic [1:0]    used,
  output logic          hit
);

  generate
    if (LOAD_LAT > 0) begin : g_sb
      localparam int CW = $clog2(LOAD_LAT + 1);
      localparam logic [CW-1:0] LAT = CW'(LOAD_LAT);

      logic [CW-1:0] cnt [1:NREGS-1];

      // Counters only move when the load's stage advances; a fresh set wins.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          for (int r = 1; r < NREGS; r++) cnt[r] <= '0;
        end else if (adv) begin
          for (int r = 1; r < NREGS; r++) begin
            if (set && set_sel == RW'(r)) cnt[r] <= LAT;
            else if (cnt[r] != '0)        cnt[r] <= cnt[r] - CW'(1);
          end
        end
      end

      always_comb begin
        hit = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
          if (cnt[r] != '0 &&
              ((rsel1 == RW'(r) && used[0]) || (rsel2 == RW'(r) && used[1])))
            hit = 1'b1;
        end
      end
    end else begin : g_no_sb
      logic unused_sb;
      assign unused_sb = ^{CLK, nRST, set, set_sel, adv, rsel1, rsel2, used};
      assign hit = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: priority-encodes dcache freeze, redirect flush,
// load-use stall and icache bubble. Define HAZ_PERF_EN for perf counters.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int RW       = 5,
  parameter int LOAD_LAT = 0
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [RW-1:0]        rsel1_id,
  input  logic [RW-1:0]        rsel2_id,
  input  logic [1:0]           rs_used_id,
  input  logic                 memread_ex,
  input  logic                 regwrite_ex,
  input  logic [RW-1:0]        wsel_ex,
  input  logic                 dmem_req,
  input  logic                 dhit,
  input  logic                 ihit,
  input  logic                 redirect_ex,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic                 idex_en,
  output logic                 idex_flush,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic [2:0]           cause,
  output logic [HZ_PERF_W-1:0] perf_loaduse,
  output logic [HZ_PERF_W-1:0] perf_dmem,
  output logic [HZ_PERF_W-1:0] perf_flush
);

  hazard_cause_t cause_c;
  logic          ex_load;
  logic          ex_hz;
  logic          sb_hz;

  assign ex_load = memread_ex && regwrite_ex && (wsel_ex != '0);
  assign ex_hz   = ex_load &&
                   ((rsel1_id == wsel_ex && rs_used_id[0]) ||
                    (rsel2_id == wsel_ex && rs_used_id[1]));

  load_scoreboard #(
    .NREGS   (NREGS),
    .RW      (RW),
    .LOAD_LAT(LOAD_LAT)
  ) u_sb (
    .CLK    (CLK),
    .nRST   (nRST),
    .set    (ex_load),
    .set_sel(wsel_ex),
    .adv    (exmem_en),
    .rsel1  (rsel1_id),
    .rsel2  (rsel2_id),
    .used   (rs_used_id),
    .hit    (sb_hz)
  );

  // A frozen EX keeps its redirect, so the dcache freeze outranks it.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    cause_c    = HZ_NONE;
    if (!nRST) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (dmem_req && !dhit) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      cause_c  = HZ_DMEM;
    end else if (redirect_ex) begin
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      cause_c    = HZ_REDIRECT;
    end else if (ex_hz || sb_hz) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      cause_c    = HZ_LOADUSE;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
      cause_c    = HZ_IMISS;
    end
  end

  assign cause = cause_c;

`ifdef HAZ_PERF_EN
  logic [HZ_PERF_W-1:0] cnt_lu, cnt_dm, cnt_fl;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_lu <= '0;
      cnt_dm <= '0;
      cnt_fl <= '0;
    end else begin
      if (cause_c == HZ_LOADUSE  && cnt_lu != '1) cnt_lu <= cnt_lu + HZ_PERF_W'(1);
      if (cause_c == HZ_DMEM     && cnt_dm != '1) cnt_dm <= cnt_dm + HZ_PERF_W'(1);
      if (cause_c == HZ_REDIRECT && cnt_fl != '1) cnt_fl <= cnt_fl + HZ_PERF_W'(1);
    end
  end

  assign perf_loaduse = cnt_lu;
  assign perf_dmem    = cnt_dm;
  assign perf_flush   = cnt_fl;
`else
  assign perf_loaduse = '0;
  assign perf_dmem    = '0;
  assign perf_flush   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: LOAD_LAT=0 and LOAD_LAT=2 instances share stimulus and
// are compared against a cycle-count model of load readiness.
module tb_hazard_ctrl;
  import cpu_types_pkg::*;

  localparam int NR = 32;

  // clock / reset
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic nRST;

  logic [4:0] rsel1_id, rsel2_id, wsel_ex;
  logic [1:0] rs_used_id;
  logic       memread_ex, regwrite_ex, dmem_req, dhit, ihit, redirect_ex;

  logic [1:0]       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
  logic [1:0][2:0]  cause_o;
  logic [1:0][31:0] perf_loaduse, perf_dmem, perf_flush;

  hazard_ctrl #(.NREGS(NR), .RW(5), .LOAD_LAT(0)) u_lat0 (
    .CLK(CLK), .nRST(nRST), .rsel1_id(rsel1_id), .rsel2_id(rsel2_id),
    .rs_used_id(rs_used_id), .memread_ex(memread_ex), .regwrite_ex(regwrite_ex),
    .wsel_ex(wsel_ex), .dmem_req(dmem_req), .dhit(dhit), .ihit(ihit),
    .redirect_ex(redirect_ex), .pc_en(pc_en[0]), .ifid_en(ifid_en[0]),
    .ifid_flush(ifid_flush[0]), .idex_en(idex_en[0]), .idex_flush(idex_flush[0]),
    .exmem_en(exmem_en[0]), .memwb_en(memwb_en[0]), .cause(cause_o[0]),
    .perf_loaduse(perf_loaduse[0]), .perf_dmem(perf_dmem[0]), .perf_flush(perf_flush[0])
  );

  hazard_ctrl #(.NREGS(NR), .RW(5), .LOAD_LAT(2)) u_lat2 (
    .CLK(CLK), .nRST(nRST), .rsel1_id(rsel1_id), .rsel2_id(rsel2_id),
    .rs_used_id(rs_used_id), .memread_ex(memread_ex), .regwrite_ex(regwrite_ex),
    .wsel_ex(wsel_ex), .dmem_req(dmem_req), .dhit(dhit), .ihit(ihit),
    .redirect_ex(redirect_ex), .pc_en(pc_en[1]), .ifid_en(ifid_en[1]),
    .ifid_flush(ifid_flush[1]), .idex_en(idex_en[1]), .idex_flush(idex_flush[1]),
    .exmem_en(exmem_en[1]), .memwb_en(memwb_en[1]), .cause(cause_o[1]),
    .perf_loaduse(perf_loaduse[1]), .perf_dmem(perf_dmem[1]), .perf_flush(perf_flush[1])
  );

  // reference model: a load's destination is busy until the global count of
  // advancing cycles reaches the value recorded when the load left EX
  int busy [2][NR];
  int adv_n;
  int m_lu [2];
  int m_dm [2];
  int m_fl [2];
  logic [9:0] exp_q [$];
  logic [2:0] last_cause [2];
  int n_chk, n_pass, n_fail;

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic logic src_match(input int r);
    return (r != 0) &&
           ((int'(rsel1_id) == r && rs_used_id[0]) || (int'(rsel2_id) == r && rs_used_id[1]));
  endfunction

  function automatic logic [2:0] ref_cause(input int k);
    logic pend;
    pend = 1'b0;
    for (int r = 1; r < NR; r++)
      if (busy[k][r] > adv_n && src_match(r)) pend = 1'b1;
    if (dmem_req && !dhit) return HZ_DMEM;
    if (redirect_ex) return HZ_REDIRECT;
    if ((memread_ex && regwrite_ex && src_match(int'(wsel_ex))) || pend) return HZ_LOADUSE;
    if (!ihit) return HZ_IMISS;
    return HZ_NONE;
  endfunction

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
  function automatic logic [6:0] ref_outs(input logic [2:0] c, input logic rst_n);
    if (!rst_n) return 7'b0010100;
    case (c)
      HZ_DMEM:     return 7'b0000000;
      HZ_REDIRECT: return 7'b1011111;
      HZ_LOADUSE:  return 7'b0001111;
      HZ_IMISS:    return 7'b0111011;
      default:     return 7'b1101011;
    endcase
  endfunction

  function automatic logic [6:0] obs_vec(input int k);
    return {pc_en[k], ifid_en[k], ifid_flush[k], idex_en[k], idex_flush[k],
            exmem_en[k], memwb_en[k]};
  endfunction

  function automatic logic [31:0] perf_exp(input int v);
`ifdef HAZ_PERF_EN
    return 32'(v);
`else
    return (v >= 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NR; r++) busy[k][r] = 0;
      m_lu[k] = 0; m_dm[k] = 0; m_fl[k] = 0;
    end
  endtask

  // driver tasks
  task automatic idle();
    rsel1_id = '0; rsel2_id = '0; wsel_ex = '0; rs_used_id = 2'b00;
    memread_ex = 1'b0; regwrite_ex = 1'b0; dmem_req = 1'b0; dhit = 1'b0;
    ihit = 1'b1; redirect_ex = 1'b0;
  endtask

  // called just after a negedge with inputs set; checks, then models the posedge
  task automatic step();
    logic [2:0] c [2];
    logic [9:0] e;
    if (!nRST) model_clear();
    #1;
    for (int k = 0; k < 2; k++) begin
      c[k] = nRST ? ref_cause(k) : 3'(HZ_NONE);
      exp_q.push_back({c[k], ref_outs(c[k], nRST)});
    end
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      chk(k == 0 ? "outs_lat0" : "outs_lat2", 32'({cause_o[k], obs_vec(k)}), 32'(e));
      chk(k == 0 ? "perf_lu_lat0" : "perf_lu_lat2", perf_loaduse[k], perf_exp(m_lu[k]));
      chk(k == 0 ? "perf_dm_lat0" : "perf_dm_lat2", perf_dmem[k], perf_exp(m_dm[k]));
      chk(k == 0 ? "perf_fl_lat0" : "perf_fl_lat2", perf_flush[k], perf_exp(m_fl[k]));
      last_cause[k] = cause_o[k];
    end
    if (nRST) begin
      for (int k = 0; k < 2; k++) begin
        if (c[k] == HZ_LOADUSE)  m_lu[k]++;
        if (c[k] == HZ_DMEM)     m_dm[k]++;
        if (c[k] == HZ_REDIRECT) m_fl[k]++;
      end
      if (c[0] != HZ_DMEM) begin
        if (memread_ex && regwrite_ex && wsel_ex != 0)
          for (int k = 0; k < 2; k++) busy[k][wsel_ex] = adv_n + 1 + lat_of(k);
        adv_n++;
      end
    end
    @(negedge CLK);
  endtask

  // load in EX with a dependent ID instruction; EX bubbles after the first cycle
  task automatic load_use_run(input logic [4:0] r, input logic src2, input int dm_cycles,
                              output int lu0, output int lu2, output int dm2);
    lu0 = 0; lu2 = 0; dm2 = 0;
    idle();
    memread_ex = 1'b1; regwrite_ex = 1'b1; wsel_ex = r;
    if (src2) begin rsel2_id = r; rs_used_id = 2'b10; end
    else      begin rsel1_id = r; rs_used_id = 2'b01; end
    for (int i = 0; i < 12; i++) begin
      dmem_req = (i >= 1 && i <= dm_cycles);
      step();
      if (last_cause[0] == HZ_LOADUSE) lu0++;
      if (last_cause[1] == HZ_LOADUSE) lu2++;
      if (last_cause[1] == HZ_DMEM)    dm2++;
      memread_ex = 1'b0; regwrite_ex = 1'b0;
    end
  endtask

  initial begin
    int lu0, lu2, dm2;
    n_chk = 0; n_pass = 0; n_fail = 0; adv_n = 0;
    model_clear();
    idle();
    nRST = 1'b0;
    @(negedge CLK);
    step(); step();
    nRST = 1'b1;
    step();

    // x5 on source 1
    load_use_run(5'd5, 1'b0, 0, lu0, lu2, dm2);
    chk("stall_len_lat0_x5", 32'(lu0), 32'd1);
    chk("stall_len_lat2_x5", 32'(lu2), 32'd3);

    // x7 on source 2
    load_use_run(5'd7, 1'b1, 0, lu0, lu2, dm2);
    chk("stall_len_lat0_x7", 32'(lu0), 32'd1);
    chk("stall_len_lat2_x7", 32'(lu2), 32'd3);

    // dcache freeze in the middle of a stall, counters fresh from reset
    nRST = 1'b0; idle(); step();
    nRST = 1'b1;
    load_use_run(5'd7, 1'b1, 4, lu0, lu2, dm2);
    chk("dmem_stall_lu_lat2", 32'(lu2), 32'd3);
    chk("dmem_stall_dm_lat2", 32'(dm2), 32'd4);
    chk("perf_dmem_after_freeze", perf_dmem[1], perf_exp(4));
    chk("perf_lu_after_freeze", perf_loaduse[1], perf_exp(3));

    // load to x0, and matching selects with no sources used
    idle(); memread_ex = 1'b1; regwrite_ex = 1'b1; rs_used_id = 2'b01;
    step();
    chk("load_x0_no_stall", 32'(last_cause[1]), 32'(HZ_NONE));
    wsel_ex = 5'd9; rsel1_id = 5'd9; rsel2_id = 5'd9; rs_used_id = 2'b00;
    step();
    chk("unused_src_no_stall", 32'(last_cause[1]), 32'(HZ_NONE));

    // redirect over load-use and imiss
    idle();
    memread_ex = 1'b1; regwrite_ex = 1'b1; wsel_ex = 5'd5; rsel1_id = 5'd5;
    rs_used_id = 2'b01; ihit = 1'b0; redirect_ex = 1'b1;
    step();
    chk("redirect_wins_lat0", 32'(last_cause[0]), 32'(HZ_REDIRECT));
    idle(); step(); step();

    // reset while x3 still has one cycle to go
    idle();
    memread_ex = 1'b1; regwrite_ex = 1'b1; wsel_ex = 5'd3; rsel1_id = 5'd3; rs_used_id = 2'b01;
    step();
    memread_ex = 1'b0; regwrite_ex = 1'b0;
    step();
    chk("x3_pending_before_reset", 32'(last_cause[1]), 32'(HZ_LOADUSE));
    nRST = 1'b0;
    step();
    chk("reset_outs_lat2", 32'(obs_vec(1)), 32'b0010100);
    nRST = 1'b1;
    step();
    chk("first_after_reset", 32'(last_cause[1]), 32'(HZ_NONE));

    // randomized traffic on a small register window
    for (int i = 0; i < 600; i++) begin
      rsel1_id    = 5'($urandom_range(0, 7));
      rsel2_id    = 5'($urandom_range(0, 7));
      wsel_ex     = 5'($urandom_range(0, 7));
      rs_used_id  = 2'($urandom_range(0, 3));
      memread_ex  = ($urandom_range(0, 2) == 0);
      regwrite_ex = ($urandom_range(0, 3) != 0);
      dmem_req    = ($urandom_range(0, 4) == 0);
      dhit        = ($urandom_range(0, 1) == 0);
      ihit        = ($urandom_range(0, 4) != 0);
      redirect_ex = ($urandom_range(0, 15) == 0);
      nRST        = ($urandom_range(0, 199) != 0);
      step();
    end
    nRST = 1'b1; idle(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
